// File: rtl/axis_uart_tx.sv
// UART transmitter: AXI-Stream byte input, small elastic FIFO, DATA_WIDTH data bits, STOP_BITS stop bits.
// Bit period is max(prescale,1)*8 clocks, latched at the start of each frame.
module axis_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [15:0]           i_prescale,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tvalid,
    output logic                  o_tready,
    output logic                  o_txd,
    output logic                  o_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Clamp prescale to at least 1; 16 bits * 8 needs 19 bits.
    function automatic logic [18:0] bit_len_of(input logic [15:0] prescale);
        logic [15:0] p;
        p = (prescale == 16'd0) ? 16'd1 : prescale;
        return {p, 3'b000};
    endfunction

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  push;
    logic                  pop;
    logic                  has_data;

    state_t                state;
    state_t                state_next;
    logic [18:0]           bit_len;
    logic [18:0]           bit_len_next;
    logic [18:0]           cnt;
    logic [18:0]           cnt_next;
    logic [BIT_W-1:0]      bit_idx;
    logic [BIT_W-1:0]      bit_idx_next;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  txd_next;
    logic                  busy_next;
    logic                  bit_done;
    logic                  start;

    // Input FIFO: o_tready already reflects !full, so a full FIFO refuses even with a same-edge pop.
    assign push       = i_tvalid && o_tready;
    assign has_data   = (count != '0);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_tdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            o_tready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            o_tready <= (count_next != CNT_W'(FIFO_DEPTH));
        end
    end

    assign bit_done = (cnt == bit_len - 19'd1);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 19'd1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        bit_len_next = bit_len;
        txd_next     = o_txd;
        busy_next    = o_busy;
        pop          = 1'b0;
        start        = 1'b0;

        case (state)
            IDLE: begin
                cnt_next  = '0;
                txd_next  = 1'b1;
                busy_next = 1'b0;
                start     = has_data;
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    txd_next     = shift[0];
                    shift_next   = shift >> 1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                        state_next   = STOP;
                        bit_idx_next = '0;
                        txd_next     = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        txd_next     = shift[0];
                        shift_next   = shift >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame when data is waiting.
                        start = has_data;
                        if (!has_data) begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (start) begin
            pop          = 1'b1;
            shift_next   = mem[rd_ptr];
            bit_len_next = bit_len_of(i_prescale);
            state_next   = START;
            cnt_next     = '0;
            txd_next     = 1'b0;
            busy_next    = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            o_txd   <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            o_txd   <= txd_next;
            o_busy  <= busy_next;
        end
    end

    always_ff @(posedge i_clk) begin
        shift   <= shift_next;
        bit_len <= bit_len_next;
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: two instances (1 and 2 stop bits) checked every cycle against a frame-level model.
module tb_axis_uart_tx;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] prescale;
    logic [7:0]  tdata  [2];
    logic        tvalid [2];
    logic        tready [2];
    logic        txd    [2];
    logic        busy   [2];

    axis_uart_tx #(.DATA_WIDTH(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_s1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_prescale(prescale),
        .i_tdata(tdata[0]), .i_tvalid(tvalid[0]), .o_tready(tready[0]),
        .o_txd(txd[0]), .o_busy(busy[0])
    );

    axis_uart_tx #(.DATA_WIDTH(8), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_s2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_prescale(prescale),
        .i_tdata(tdata[1]), .i_tvalid(tvalid[1]), .o_tready(tready[1]),
        .o_txd(txd[1]), .o_busy(busy[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents plus the start edge and bit length of the frame on the line.
    int         cyc = 0;
    logic [7:0] mf [2][DEPTH];
    int         mh [2];
    int         mc [2];
    int         m_t0 [2];
    int         m_L [2];
    bit         m_rdy [2];
    bit         m_act [2];
    logic [7:0] m_byte [2];

    function automatic int frame_len(input int u);
        return (1 + DW + (u + 1)) * m_L[u];
    endfunction

    function automatic logic exp_txd(input int u);
        int b;
        if (!m_act[u]) return 1'b1;
        b = (cyc - m_t0[u]) / m_L[u];
        if (b == 0) return 1'b0;
        if (b <= DW) return m_byte[u][b-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input int u);
        bit push;
        if (!rst_n) begin
            mc[u] = 0; mh[u] = 0; m_act[u] = 0; m_rdy[u] = 1;
            return;
        end
        push = tvalid[u] && m_rdy[u];
        if (m_act[u] && cyc == m_t0[u] + frame_len(u)) m_act[u] = 0;
        if (!m_act[u] && mc[u] > 0) begin
            m_byte[u] = mf[u][mh[u]];
            mh[u]     = (mh[u] + 1) % DEPTH;
            mc[u]--;
            m_act[u]  = 1;
            m_t0[u]   = cyc;
            m_L[u]    = ((prescale == 16'd0) ? 1 : int'(prescale)) * 8;
        end
        if (push) begin
            mf[u][(mh[u] + mc[u]) % DEPTH] = tdata[u];
            mc[u]++;
        end
        m_rdy[u] = (mc[u] < DEPTH);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        for (int u = 0; u < 2; u++) model_edge(u);
        #1;
        for (int u = 0; u < 2; u++) begin
            check_eq($sformatf("txd%0d", u), 32'(txd[u]), 32'(exp_txd(u)));
            check_eq($sformatf("busy%0d", u), 32'(busy[u]), 32'(m_act[u]));
            check_eq($sformatf("tready%0d", u), 32'(tready[u]), 32'(m_rdy[u]));
        end
    endtask

    // Per-unit byte sources and per-run line statistics.
    logic [7:0] src [2][8];
    int src_n [2];
    int src_i [2];
    int busy_cnt [2];
    int low_cnt [2];
    int high_cnt [2];
    int busy_runs [2];

    task automatic clear_src();
        for (int u = 0; u < 2; u++) begin
            src_n[u] = 0; src_i[u] = 0;
        end
    endtask

    task automatic load(input int u, input logic [7:0] b);
        src[u][src_n[u]] = b;
        src_n[u]++;
    endtask

    function automatic bit pending();
        for (int u = 0; u < 2; u++)
            if (src_i[u] < src_n[u] || mc[u] > 0 || m_act[u]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run(input int budget, input bit until_idle, input int chg_at, input logic [15:0] chg_ps);
        int n;
        bit acc [2];
        bit prev [2];
        bit more;
        n = 0;
        more = 1'b1;
        for (int u = 0; u < 2; u++) begin
            busy_cnt[u] = 0; low_cnt[u] = 0; high_cnt[u] = 0; busy_runs[u] = 0; prev[u] = 1'b0;
        end
        while (more && n < budget) begin
            if (n == chg_at) prescale = chg_ps;
            for (int u = 0; u < 2; u++) begin
                tvalid[u] = (src_i[u] < src_n[u]);
                tdata[u]  = tvalid[u] ? src[u][src_i[u]] : 8'($urandom);
                acc[u]    = tvalid[u] && tready[u];
            end
            step();
            for (int u = 0; u < 2; u++) begin
                if (acc[u]) src_i[u]++;
                if (busy[u] === 1'b1) begin
                    busy_cnt[u]++;
                    if (!prev[u]) busy_runs[u]++;
                    if (txd[u] === 1'b1) high_cnt[u]++;
                    else low_cnt[u]++;
                end
                prev[u] = (busy[u] === 1'b1);
            end
            n++;
            if (until_idle) more = pending();
        end
        tvalid[0] = 1'b0;
        tvalid[1] = 1'b0;
        if (until_idle) check_eq("idle_timeout", 32'(more), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        prescale  = 16'd1;
        tvalid[0] = 1'b0; tvalid[1] = 1'b0;
        tdata[0]  = 8'h00; tdata[1]  = 8'h00;
        clear_src();
        step();
        step();
        check_eq("rst_txd0", 32'(txd[0]), 32'd1);
        check_eq("rst_busy0", 32'(busy[0]), 32'd0);
        check_eq("rst_tready0", 32'(tready[0]), 32'd1);
        rst_n = 1'b1;

        // Single byte 0x41 at 8-clock bits
        clear_src(); load(0, 8'h41); load(1, 8'h41);
        run(400, 1'b1, -1, 16'd0);
        check_eq("t1_busy_s1", busy_cnt[0], 80);
        check_eq("t1_busy_s2", busy_cnt[1], 88);
        check_eq("t1_low_s1", low_cnt[0], 56);
        check_eq("t1_high_s1", high_cnt[0], 24);

        // Burst of six bytes held on tvalid
        clear_src();
        for (int b = 0; b < 6; b++) begin
            load(0, 8'(b)); load(1, 8'(b));
        end
        run(2000, 1'b1, -1, 16'd0);
        check_eq("t2_busy_s1", busy_cnt[0], 480);
        check_eq("t2_busy_s2", busy_cnt[1], 528);
        check_eq("t2_runs_s1", busy_runs[0], 1);
        check_eq("t2_runs_s2", busy_runs[1], 1);

        // Prescale change mid-DATA only affects the next frame
        prescale = 16'd100;
        clear_src(); load(0, 8'h55); load(0, 8'hAA); load(1, 8'h55); load(1, 8'hAA);
        run(20000, 1'b1, 3000, 16'd2);
        check_eq("t3_busy_s1", busy_cnt[0], 8160);
        check_eq("t3_busy_s2", busy_cnt[1], 8976);
        check_eq("t3_runs_s1", busy_runs[0], 1);

        // Reset mid-DATA with two bytes queued
        prescale = 16'd1;
        clear_src();
        load(0, 8'h11); load(0, 8'h22); load(0, 8'h33);
        load(1, 8'h11); load(1, 8'h22); load(1, 8'h33);
        run(20, 1'b0, -1, 16'd0);
        check_eq("t4_queued_s1", 32'(tready[0]), 32'd1);
        check_eq("t4_busy_pre", 32'(busy[0]), 32'd1);
        src_n[0] = src_i[0]; src_n[1] = src_i[1];
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int u = 0; u < 2; u++) begin
            check_eq($sformatf("t4_txd%0d", u), 32'(txd[u]), 32'd1);
            check_eq($sformatf("t4_busy%0d", u), 32'(busy[u]), 32'd0);
            check_eq($sformatf("t4_tready%0d", u), 32'(tready[u]), 32'd1);
        end
        run(200, 1'b0, -1, 16'd0);
        check_eq("t4_after_s1", busy_cnt[0], 0);
        check_eq("t4_after_s2", busy_cnt[1], 0);

        // 0xFF frame: two stop bits on the second unit
        clear_src(); load(0, 8'hFF); load(1, 8'hFF);
        run(400, 1'b1, -1, 16'd0);
        check_eq("t5_busy_s2", busy_cnt[1], 88);
        check_eq("t5_low_s2", low_cnt[1], 8);
        check_eq("t5_high_s2", high_cnt[1], 80);
        check_eq("t5_busy_s1", busy_cnt[0], 80);

        // Prescale 0 behaves as 1
        prescale = 16'd0;
        clear_src(); load(0, 8'h00); load(1, 8'h00);
        run(400, 1'b1, -1, 16'd0);
        check_eq("t6_busy_s1", busy_cnt[0], 80);
        check_eq("t6_low_s1", low_cnt[0], 72);
        check_eq("t6_busy_s2", busy_cnt[1], 88);

        // Maximum prescale: start bit must hold well past any short counter wrap
        prescale = 16'hFFFF;
        clear_src(); load(0, 8'h00);
        run(2000, 1'b0, -1, 16'd0);
        check_eq("t7_low_s1", low_cnt[0], 1999);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Randomized traffic, prescale changes and occasional resets
        prescale = 16'd1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) prescale = 16'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 999) != 0);
            for (int u = 0; u < 2; u++) begin
                tvalid[u] = ($urandom_range(0, 2) == 0);
                tdata[u]  = 8'($urandom);
            end
            step();
        end
        rst_n = 1'b1;
        tvalid[0] = 1'b0; tvalid[1] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axis_uart_tx.md
Name: axis_uart_tx

Overview:
- Standalone 8N1 (configurable) UART transmitter with AXI-Stream-style byte input and a small elastic FIFO.
- Drives TXD_PC from host-side producers such as the keyboard mapper, so bursts of mapped keys are not lost while a frame is on the line.
- Bit-timing convention matches the receive path: bit period = prescale × 8 clocks. At 12 MHz, prescale 1250 gives 1200 baud.

Parameters:
- DATA_WIDTH, 8: data bits per frame, sent LSB first.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries; power of 2, ≥ 2.

Ports:
- i_clk  in  1: system clock (12 MHz in this design).
- i_rst_n  in  1: reset, synchronous, active-low.
- i_prescale  in  16: clocks per bit ÷ 8; value 0 is treated as 1.
- i_tdata  in  DATA_WIDTH: byte to send.
- i_tvalid  in  1: i_tdata valid.
- o_tready  out  1: FIFO can accept a byte.
- o_txd  out  1: serial line; idle high.
- o_busy  out  1: a frame is on the line.

Behaviour:
- Reset (i_rst_n low at a rising edge): o_txd=1, o_busy=0, o_tready=1, FIFO emptied, FSM goes to IDLE.
- Reset mid-frame abandons the frame at that edge: line returns high and queued bytes are discarded.
- Handshake: a byte is written on an edge where i_tvalid && o_tready. o_tready is registered and equals !full, using post-edge occupancy.
  - When the FIFO is full, a push is refused even if a pop happens on the same edge.
  - Simultaneous push and pop with 1 ≤ count < DEPTH leaves the count unchanged.
  - i_tdata and i_tvalid are ignored while o_tready=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_txd=1, o_busy=0. If the FIFO is non-empty at an edge:
    - pop the head into the shift register;
    - latch max(i_prescale,1)×8 as bit length;
    - go to START, with o_txd=0 and o_busy=1 from that edge.
  - START: hold 0 for one bit length, then go to DATA.
  - DATA: shift out DATA_WIDTH bits LSB first, each one bit length. Then go to STOP with o_txd=1.
  - STOP: hold 1 for STOP_BITS × bit length. At the final edge:
    - if the FIFO is non-empty: pop, relatch prescale, go directly to START (no idle gap; o_busy stays 1);
    - otherwise: go to IDLE (o_busy=0).
- Latency: a byte accepted at edge n into an empty FIFO with the FSM in IDLE is popped at edge n+1, and o_txd falls at edge n+1.
- Frame length = (1 + DATA_WIDTH + STOP_BITS) × bit length clocks, exact to the cycle.
- Prescale is sampled only at frame start. Changes mid-frame affect only the next frame.
- Bit counter: 16-bit prescale × 8 needs a 19-bit counter; no overflow is permitted at prescale=0xFFFF.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Single byte, prescale=1, i_tdata=0x41, one-cycle tvalid at edge n.
   - o_txd low from edge n+1 for 8 clocks.
   - Then bits 1,0,0,0,0,0,1,0 at 8 clocks each, then stop high for 8 clocks.
   - o_busy high for exactly 80 clocks, then IDLE.
2. Burst: prescale=1, tvalid held with bytes 0x00..0x05.
   - 5 bytes accepted on consecutive edges (1 popped immediately + 4 fill the FIFO), then o_tready=0.
   - o_tready reasserts after each pop.
   - All 6 frames sent in order, back-to-back: o_busy continuously high for 480 clocks.
3. Prescale change: prescale=1250, send 0x55.
   - Each bit lasts 10000 clocks.
   - Set prescale=2 mid-DATA; the current frame is unaffected.
   - The next queued byte 0xAA uses 16-clock bits.
4. Reset mid-DATA with 2 bytes queued (i_rst_n low for 1 edge).
   - At that edge: o_txd=1, o_busy=0, o_tready=1.
   - No further frames are sent after reset releases.
5. STOP_BITS=2, prescale=1, byte 0xFF: o_txd low 8 clocks, then high 80 clocks; o_busy high for 88 clocks.
6. prescale=0, byte 0x00: behaves identically to prescale=1, with 8-clock bits and an 80-clock frame.
